// File: rtl/mby_egr_dirty_pod_inj_if.sv
// Dirty-pod push port plus upstream/downstream pod pointer ring slots for mby_egr_dirty_pod_inj.
// master = the side that offers pods and feeds the ring; slave = the injector.
interface mby_egr_dirty_pod_inj_if #(
    parameter int POD_PTR_W = 16
);
    logic                 dpod_vld;
    logic [POD_PTR_W-1:0] dpod_ptr;
    logic                 dpod_rdy;
    logic                 ring_in_vld;
    logic                 ring_in_dirty;
    logic [POD_PTR_W-1:0] ring_in_ptr;
    logic                 ring_out_vld;
    logic                 ring_out_dirty;
    logic [POD_PTR_W-1:0] ring_out_ptr;

    modport master (
        output dpod_vld, dpod_ptr, ring_in_vld, ring_in_dirty, ring_in_ptr,
        input  dpod_rdy, ring_out_vld, ring_out_dirty, ring_out_ptr
    );

    modport slave (
        input  dpod_vld, dpod_ptr, ring_in_vld, ring_in_dirty, ring_in_ptr,
        output dpod_rdy, ring_out_vld, ring_out_dirty, ring_out_ptr
    );
endinterface

// File: rtl/mby_egr_dirty_pod_inj.sv
// Egress dirty-pod injector / 1-flop pod ring repeater with GPM stall holdoff.
// Optional statistics counters are enabled by defining MBY_EGR_POD_INJ_STATS_EN.
module mby_egr_dirty_pod_inj #(
    parameter int POD_PTR_W  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RESUME_DLY = 4
) (
    input  logic                              cclk,
    input  logic                              reset_n,
    mby_egr_dirty_pod_inj_if.slave            bus,
    input  logic                              pod_ring_stall,
    input  logic                              inj_en,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
`ifdef MBY_EGR_POD_INJ_STATS_EN
    ,
    output logic [31:0]                       inj_cnt,
    output logic [31:0]                       stall_cyc_cnt
`endif
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (RESUME_DLY > 1) ? $clog2(RESUME_DLY) : 1;

    typedef enum logic [1:0] {RUN, STALL, RESUME} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [POD_PTR_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic                 push_p0, inj_p0;
    logic                 out_vld_p1, out_dirty_p1;
    logic [POD_PTR_W-1:0] out_ptr_p1;

    // Stage p0: admission and injection decision from registered state
    assign bus.dpod_rdy = (level_q < LVL_W'(FIFO_DEPTH));
    assign push_p0      = bus.dpod_vld & bus.dpod_rdy;
    assign inj_p0       = (state_q == RUN) & ~pod_ring_stall & inj_en &
                          ~bus.ring_in_vld & (level_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (pod_ring_stall) state_d = STALL;
            end
            STALL: begin
                if (!pod_ring_stall) begin
                    if (RESUME_DLY == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d = RESUME;
                        cnt_d   = CNT_W'(RESUME_DLY - 1);
                    end
                end
            end
            RESUME: begin
                if (pod_ring_stall)     state_d = STALL;
                else if (cnt_q == '0)   state_d = RUN;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_p0) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (inj_p0)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_p0, inj_p0})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Buffer storage holds data only; occupancy is tracked by the pointers above
    always_ff @(posedge cclk) begin
        if (push_p0) mem[wr_ptr_q] <= bus.dpod_ptr;
    end

    // Stage p1: registered ring slot; occupied upstream slots always win
    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_p1   <= 1'b0;
            out_dirty_p1 <= 1'b0;
            out_ptr_p1   <= '0;
        end else if (bus.ring_in_vld) begin
            out_vld_p1   <= 1'b1;
            out_dirty_p1 <= bus.ring_in_dirty;
            out_ptr_p1   <= bus.ring_in_ptr;
        end else if (inj_p0) begin
            out_vld_p1   <= 1'b1;
            out_dirty_p1 <= 1'b1;
            out_ptr_p1   <= mem[rd_ptr_q];
        end else begin
            out_vld_p1   <= 1'b0;
            out_dirty_p1 <= 1'b0;
        end
    end

    assign bus.ring_out_vld   = out_vld_p1;
    assign bus.ring_out_dirty = out_dirty_p1;
    assign bus.ring_out_ptr   = out_ptr_p1;
    assign fifo_level         = level_q;

`ifdef MBY_EGR_POD_INJ_STATS_EN
    logic [31:0] inj_cnt_q, stall_cnt_q;

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            inj_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (inj_p0 && (inj_cnt_q != 32'hFFFF_FFFF))
                inj_cnt_q <= inj_cnt_q + 32'd1;
            if ((state_q != RUN) && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign inj_cnt       = inj_cnt_q;
    assign stall_cyc_cnt = stall_cnt_q;
`endif
endmodule
